sr_latch_bank: RTL and testbench

SR_LATCH_BANK -- requirements
Module: sr_latch_bank

---
 rtl/sr_latch_bank.sv | 119 +++++++++++
 tb/tb_sr_latch_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank.sv
// Bank of independent clocked SR latches with active-low asynchronous set/reset
// inputs. Each input is synchronised, then resolved per channel into a registered
// Q/Qn pair, edge pulses, an invalid (both-low) flag and a saturating invalid counter.
module sr_latch_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MODE        = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   S_n,
    input  logic [WIDTH-1:0]   R_n,
    input  logic               cnt_clr,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   Qn,
    output logic [WIDTH-1:0]   q_rise,
    output logic [WIDTH-1:0]   q_fall,
    output logic [WIDTH-1:0]   invalid,
    output logic [COUNT_W-1:0] invalid_count
);

    logic [WIDTH-1:0]   r_s_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   r_r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic [WIDTH-1:0]   r_invalid;
    logic [WIDTH-1:0]   r_both_prev;
    logic [COUNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_both;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_any;
    logic               w_sat;

    // Synchroniser chains; reset to 1 (deasserted) so reset release creates no events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_s_sync[k] <= '1;
                r_r_sync[k] <= '1;
            end
        end else begin
            r_s_sync[0] <= S_n;
            r_r_sync[0] <= R_n;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_s_sync[k] <= r_s_sync[k-1];
                r_r_sync[k] <= r_r_sync[k-1];
            end
        end
    end

    assign w_s    = r_s_sync[SYNC_STAGES-1];
    assign w_r    = r_r_sync[SYNC_STAGES-1];
    assign w_both = ~w_s & ~w_r;
    assign w_any  = |w_both;
    assign w_sat  = &r_cnt;

    // Per-channel next-state resolution of the synchronised set/reset pair.
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({w_s[i], w_r[i]})
                2'b01:   w_q_next[i] = 1'b1;
                2'b10:   w_q_next[i] = 1'b0;
                2'b11:   w_q_next[i] = r_q[i];
                default: begin
                    case (MODE)
                        1:       w_q_next[i] = 1'b1;
                        2:       w_q_next[i] = 1'b0;
                        // Toggle only on entry into both-low, then hold until re-entry.
                        3:       w_q_next[i] = r_both_prev[i] ? r_q[i] : ~r_q[i];
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
            endcase
        end
    end

    // Latch state, edge pulses, invalid flags and toggle history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
            r_invalid   <= '0;
            r_both_prev <= '0;
        end else begin
            r_q         <= w_q_next;
            r_rise      <= w_q_next & ~r_q;
            r_fall      <= ~w_q_next & r_q;
            r_invalid   <= w_both;
            r_both_prev <= w_both;
        end
    end

    // Saturating count of cycles with any channel invalid; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_any && !w_sat) begin
            r_cnt <= r_cnt + COUNT_W'(1);
        end
    end

    // Qn derives from the same register so Q=Qn=1 can never be observed.
    assign Q             = r_q;
    assign Qn            = ~r_q;
    assign q_rise        = r_rise;
    assign q_fall        = r_fall;
    assign invalid       = r_invalid;
    assign invalid_count = r_cnt;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank: four instances (MODE 0..3) plus a COUNT_W=4
// instance share the same stimulus; expectations go through a scoreboard queue.
module tb_sr_latch_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_n = 8'hFF;
    logic [7:0] r_n = 8'hFF;
    logic       cnt_clr = 1'b0;

    logic [7:0] q    [4];
    logic [7:0] qn   [4];
    logic [7:0] rise [4];
    logic [7:0] fall [4];
    logic [7:0] inv  [4];
    logic [7:0] cnt  [4];

    logic [7:0] q4, qn4, rise4, fall4, inv4;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_latch_bank #(
            .WIDTH(8), .MODE(m), .SYNC_STAGES(2), .COUNT_W(8)
        ) u_dut (
            .clk(clk), .rst(rst), .S_n(s_n), .R_n(r_n), .cnt_clr(cnt_clr),
            .Q(q[m]), .Qn(qn[m]), .q_rise(rise[m]), .q_fall(fall[m]),
            .invalid(inv[m]), .invalid_count(cnt[m])
        );
    end

    sr_latch_bank #(
        .WIDTH(8), .MODE(0), .SYNC_STAGES(2), .COUNT_W(4)
    ) u_dut_cw4 (
        .clk(clk), .rst(rst), .S_n(s_n), .R_n(r_n), .cnt_clr(cnt_clr),
        .Q(q4), .Qn(qn4), .q_rise(rise4), .q_fall(fall4),
        .invalid(inv4), .invalid_count(cnt4)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %0h, no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h, expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pulses();
        logic [7:0] a;
        a = rise4 | fall4 | inv4;
        for (int m = 0; m < 4; m++) a |= rise[m] | fall[m] | inv[m];
        return a;
    endfunction

    logic [7:0] acc;
    int         ninv;
    int         nrise;
    int         nfall;
    logic       lo;

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            push("rst_q", 0);
            push("rst_qn", 8'hFF);
            push("rst_invalid", 0);
            push("rst_count", 0);
        end
        push("rst_count_cw4", 0);
        #1;
        for (int m = 0; m < 4; m++) begin
            pop_check(q[m]);
            pop_check(qn[m]);
            pop_check(inv[m]);
            pop_check(cnt[m]);
        end
        pop_check(cnt4);
        tick();
        tick();
        rst = 1'b0;
        push("release_pulses", 0);
        acc = '0;
        repeat (4) begin
            tick();
            acc |= pulses();
        end
        pop_check(acc);

        // Single-cycle set on channel 3, latency of SYNC_STAGES+1 edges.
        s_n[3] = 1'b0;
        push("set3_latency_q", 0);
        push("set3_q", 1);
        push("set3_rise", 8'h08);
        push("set3_qn", 0);
        tick();
        s_n[3] = 1'b1;
        tick();
        pop_check(q[0][3]);
        tick();
        pop_check(q[0][3]);
        pop_check(rise[0]);
        pop_check(qn[0][3]);
        push("set3_rise_off", 0);
        push("set3_q_hold", 1);
        tick();
        pop_check(rise[0][3]);
        pop_check(q[0][3]);

        // Establish Q[0]=1, then hold both low for four cycles.
        s_n[0] = 1'b0;
        tick();
        s_n[0] = 1'b1;
        repeat (3) tick();
        s_n[0] = 1'b0;
        r_n[0] = 1'b0;
        push("bothlow_inv_cycles", 4);
        ninv = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                s_n[0] = 1'b1;
                r_n[0] = 1'b1;
            end
            tick();
            ninv += int'(inv[0][0]);
        end
        pop_check(ninv);
        push("mode0_q0", 1);
        push("mode1_q0", 1);
        push("mode2_q0", 0);
        push("mode3_q0", 0);
        for (int m = 0; m < 4; m++) push("bothlow_count", 4);
        push("bothlow_count_cw4", 4);
        for (int m = 0; m < 4; m++) pop_check(q[m][0]);
        for (int m = 0; m < 4; m++) pop_check(cnt[m]);
        pop_check(cnt4);

        // MODE 3 on channel 1: low 3, high 2, low 2 -> one rise, one fall.
        push("toggle_rises", 1);
        push("toggle_falls", 1);
        push("toggle_final_q", 0);
        push("mode1_q1", 1);
        push("mode0_q1", 0);
        push("toggle_count", 9);
        nrise = 0;
        nfall = 0;
        for (int i = 0; i < 14; i++) begin
            lo = (i < 3) || (i == 5) || (i == 6);
            s_n[1] = ~lo;
            r_n[1] = ~lo;
            tick();
            nrise += int'(rise[3][1]);
            nfall += int'(fall[3][1]);
        end
        pop_check(nrise);
        pop_check(nfall);
        pop_check(q[3][1]);
        pop_check(q[1][1]);
        pop_check(q[0][1]);
        pop_check(cnt[0]);

        // Saturation on the 4-bit counter with two channels invalid at once.
        cnt_clr = 1'b1;
        push("clr_cw4", 0);
        push("clr_cnt0", 0);
        tick();
        cnt_clr = 1'b0;
        pop_check(cnt4);
        pop_check(cnt[0]);
        s_n = s_n & ~8'h24;
        r_n = r_n & ~8'h24;
        push("sat_cw4", 15);
        push("per_cycle_cnt0", 23);
        push("sat_invalid", 8'h24);
        repeat (25) tick();
        pop_check(cnt4);
        pop_check(cnt[0]);
        pop_check(inv[0]);
        cnt_clr = 1'b1;
        push("clr_during_inv_cw4", 0);
        push("clr_during_inv_cnt0", 0);
        tick();
        pop_check(cnt4);
        pop_check(cnt[0]);
        cnt_clr = 1'b0;
        push("after_clr_cw4", 1);
        tick();
        pop_check(cnt4);
        s_n = s_n | 8'h24;
        r_n = r_n | 8'h24;
        repeat (4) tick();

        // Load 0xA5, then asynchronous reset between edges.
        s_n = 8'h5A;
        r_n = 8'hA5;
        for (int m = 0; m < 4; m++) push("load_a5", 8'hA5);
        repeat (3) tick();
        for (int m = 0; m < 4; m++) pop_check(q[m]);
        s_n = 8'hFF;
        r_n = 8'hFF;
        repeat (3) tick();
        #3 rst = 1'b1;
        push("async_rst_q", 0);
        push("async_rst_qn", 8'hFF);
        #1;
        pop_check(q[0]);
        pop_check(qn[0]);
        #2 rst = 1'b0;
        push("post_rst_pulses", 0);
        acc = '0;
        repeat (5) begin
            tick();
            acc |= pulses();
        end
        pop_check(acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
